// File: rtl/mem_access_ctrl_pkg.sv
// proc_pkg: shared types and default parameters for the memory access stage.
//   mac_state_t : access FSM states (IDLE, REQ, ABORT)
//   MAC_ADDR_W  : default address width
//   MAC_DATA_W  : default data width
//   MAC_TIMEOUT : default cycles allowed for mem_ack before abort
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ABORT = 2'd2
    } mac_state_t;

    localparam int unsigned MAC_ADDR_W  = 8;
    localparam int unsigned MAC_DATA_W  = 8;
    localparam int unsigned MAC_TIMEOUT = 15;

endpackage

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// mem_timeout_ctr: 8-bit wait counter for the memory access stage.
//   clock   : rising-edge clock
//   resetn  : asynchronous active-low reset
//   clr     : synchronous clear to 0 (has priority over en)
//   en      : increment by one
//   expired : count has reached TIMEOUT-1
module mem_timeout_ctr
    import proc_pkg::*;
#(
    parameter int unsigned TIMEOUT = MAC_TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: converts level MemRead/MemWrite strobes from the multicycle
// control FSM into a req/ack handshake with variable-latency memory.
//   clock, resetn          : rising-edge clock, asynchronous active-low reset
//   MemRead, MemWrite      : level strobes from control FSM
//   AddrSel                : 1 selects pc_addr, 0 selects data_addr
//   pc_addr, data_addr     : candidate request addresses
//   wr_data                : store data
//   stall                  : freezes control FSM and datapath enables
//   rd_data                : read data to IR/MDR (bypassed in the ack cycle)
//   mem_req/we/addr/wdata  : request to memory, stable while mem_req=1
//   mem_ack, mem_rdata     : single-cycle completion and its read data
//   err                    : sticky timeout / illegal-strobe flag
// Optional build macro MEM_ACCESS_PERF_EN adds saturating 16-bit outputs
// perf_rd_cnt, perf_wr_cnt, perf_stall_cnt.
module mem_access_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned ADDR_W  = MAC_ADDR_W,
    parameter int unsigned DATA_W  = MAC_DATA_W,
    parameter int unsigned TIMEOUT = MAC_TIMEOUT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              AddrSel,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [15:0]       perf_rd_cnt,
    output logic [15:0]       perf_wr_cnt,
    output logic [15:0]       perf_stall_cnt
`endif
);

    mac_state_t        state, next_state;
    logic [DATA_W-1:0] rd_q;
    logic              one_strobe;
    logic              both_strobes;
    logic              expired;
    logic              ack_hit;

    assign one_strobe   = MemRead ^ MemWrite;
    assign both_strobes = MemRead & MemWrite;
    assign ack_hit      = (state == REQ) && mem_ack;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .resetn  (resetn),
        .clr     (state != REQ),
        .en      (state == REQ),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (one_strobe) next_state = REQ;
            REQ: begin
                if (mem_ack)      next_state = IDLE;
                else if (expired) next_state = ABORT;
            end
            ABORT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: stall is combinational so the control FSM freezes on the
    // strobe cycle itself and is released in the ack cycle.
    always_comb begin
        stall = 1'b0;
        unique case (state)
            IDLE:    stall = one_strobe;
            REQ:     stall = !mem_ack;
            default: stall = 1'b0;
        endcase
        rd_data = ack_hit ? mem_rdata : rd_q;
    end

    // Request registers, read capture and sticky error
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_q      <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (one_strobe) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= AddrSel ? pc_addr : data_addr;
                        mem_wdata <= wr_data;
                    end else if (both_strobes) begin
                        err <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) rd_q <= mem_rdata;
                    end else if (expired) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (ack_hit && !mem_we && perf_rd_cnt != '1)
                perf_rd_cnt <= perf_rd_cnt + 16'd1;
            if (ack_hit && mem_we && perf_wr_cnt != '1)
                perf_wr_cnt <= perf_wr_cnt + 16'd1;
            if (stall && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule
